// File: rtl/period_timer.sv
`default_nettype none
// ============================================================================
// Module      : period_timer
// Description : Programmable-period tick generator. Emits a one-cycle strobe
//               (o_valid) at the end of each period and a 50 %-duty square
//               wave (o_toggle) that flips on every strobe. Four periods are
//               chosen at run time via i_sel. Periodic and one-shot modes are
//               supported, along with pause (i_enable=0) and restart
//               (i_start). Period and mode are latched only at latch points
//               (start, IDLE->RUN entry, periodic terminal count), so changes
//               to i_sel/i_mode never disturb a period in progress.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   1      system clock, rising edge
//   i_rst     in   1      asynchronous active-low reset
//   i_enable  in   1      count enable; 0 pauses and holds all state
//   i_sel     in   2      period select (sampled at latch points)
//   i_mode    in   1      0 = periodic, 1 = one-shot (sampled at latch points)
//   i_start   in   1      single-cycle restart/arm request
//   o_valid   out  1      one-cycle strobe at period end
//   o_toggle  out  1      inverts on every o_valid
//   o_busy    out  1      high while in RUN
//   o_count   out  CNT_W  current counter value
// ============================================================================
module period_timer #(
    parameter int          CNT_W   = 32,
    parameter int unsigned PERIOD0 = 100_000_000,
    parameter int unsigned PERIOD1 = 50_000_000,
    parameter int unsigned PERIOD2 = 25_000_000,
    parameter int unsigned PERIOD3 = 10_000_000
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [1:0]       i_sel,
    input  logic             i_mode,
    input  logic             i_start,
    output logic             o_valid,
    output logic             o_toggle,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_count
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    localparam longint unsigned c_max_val = (64'd1 << CNT_W) - 64'd1;

    generate
        if ((PERIOD0 == 0) || (PERIOD1 == 0) || (PERIOD2 == 0) || (PERIOD3 == 0)) begin : g_zero_period
            $error("period_timer: every PERIODn must be >= 1");
        end
        if ((64'(PERIOD0) > c_max_val) || (64'(PERIOD1) > c_max_val) ||
            (64'(PERIOD2) > c_max_val) || (64'(PERIOD3) > c_max_val)) begin : g_wide_period
            $error("period_timer: every PERIODn must fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_p0  = CNT_W'(PERIOD0);
    localparam logic [CNT_W-1:0] c_p1  = CNT_W'(PERIOD1);
    localparam logic [CNT_W-1:0] c_p2  = CNT_W'(PERIOD2);
    localparam logic [CNT_W-1:0] c_p3  = CNT_W'(PERIOD3);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_count,  w_count_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_mode,   w_mode_nxt;
    logic             r_valid,  w_valid_nxt;
    logic             r_toggle, w_toggle_nxt;
    logic             r_busy,   w_busy_nxt;

    logic [CNT_W-1:0] w_sel_period;
    logic             w_tc;

    // Period table lookup for the current select value
    always_comb begin
        w_sel_period = c_p0;
        case (i_sel)
            2'b00:   w_sel_period = c_p0;
            2'b01:   w_sel_period = c_p1;
            2'b10:   w_sel_period = c_p2;
            default: w_sel_period = c_p3;
        endcase
    end

    // Terminal count: the last enabled cycle of the latched period.
    // period >= 1 always, so period-1 never underflows.
    assign w_tc = (r_state == S_RUN) && i_enable && (r_count == (r_period - c_one));

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_period_nxt = r_period;
        w_mode_nxt   = r_mode;
        w_valid_nxt  = 1'b0;
        w_toggle_nxt = r_toggle;

        case (r_state)
            S_IDLE: begin
                if (i_start || (i_enable && !i_mode)) begin
                    w_state_nxt  = S_RUN;
                    w_count_nxt  = '0;
                    w_period_nxt = w_sel_period;
                    w_mode_nxt   = i_mode;
                end
            end

            S_RUN: begin
                // The strobe and toggle are produced on terminal count even
                // when a restart lands on the same cycle.
                if (w_tc) begin
                    w_valid_nxt  = 1'b1;
                    w_toggle_nxt = ~r_toggle;
                end

                if (i_start) begin
                    // Restart wins over one-shot completion: stay in RUN.
                    w_count_nxt  = '0;
                    w_period_nxt = w_sel_period;
                    w_mode_nxt   = i_mode;
                end else if (w_tc) begin
                    w_count_nxt = '0;
                    if (r_mode) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_period_nxt = w_sel_period;
                        w_mode_nxt   = i_mode;
                    end
                end else if (i_enable) begin
                    w_count_nxt = r_count + c_one;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Busy is registered from the next state so it changes on the same
        // edge that enters or leaves RUN.
        w_busy_nxt = (w_state_nxt == S_RUN);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_period <= c_p0;
            r_mode   <= 1'b0;
            r_valid  <= 1'b0;
            r_toggle <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_period <= w_period_nxt;
            r_mode   <= w_mode_nxt;
            r_valid  <= w_valid_nxt;
            r_toggle <= w_toggle_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign o_valid  = r_valid;
    assign o_toggle = r_toggle;
    assign o_busy   = r_busy;
    assign o_count  = r_count;

endmodule
`default_nettype wire

// File: doc/period_timer.md
# period_timer

Parametrised tick generator for the LED blink/move datapath. A programmable-period counter emits a one-cycle `o_valid` strobe and a 50 %-duty `o_toggle` square wave. It supports four parameter-defined periods selected at run time, periodic and one-shot modes, pause/resume, and glitch-free period changes that take effect only at the period boundary.

## Interface
- `CNT_W`, 32: counter width; every `PERIODn` must fit in `CNT_W` bits.
- `PERIOD0`, 100_000_000: period in clk cycles for `i_sel=2'b00` (1000 ms at 100 MHz).
- `PERIOD1`, 50_000_000: period for `i_sel=2'b01` (500 ms).
- `PERIOD2`, 25_000_000: period for `i_sel=2'b10` (250 ms).
- `PERIOD3`, 10_000_000: period for `i_sel=2'b11` (100 ms).
- Every `PERIODn` is ≥1. Values of 0 are illegal; an elaboration-time check flags them.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-low reset (0 = reset); deassertion is synchronous to `clk` upstream.
- `i_enable`  in  1  count enable; 0 pauses the counter and holds all state.
- `i_sel`  in  2  period select; sampled only at latch points.
- `i_mode`  in  1  0 = periodic, 1 = one-shot; sampled only at latch points.
- `i_start`  in  1  single-cycle restart/arm request.
- `o_valid`  out  1  one-cycle strobe at period end (registered).
- `o_toggle`  out  1  inverts on every `o_valid` (registered).
- `o_busy`  out  1  1 while in RUN (registered).
- `o_count`  out  CNT_W  current counter value.

## Operation
- Internal state: `state` ∈ {IDLE, RUN}, `count[CNT_W-1:0]`, latched `period`, latched `mode`.
- Reset (`i_rst`=0, asynchronous) sets: `state`=IDLE, `count`=0, `period`=PERIOD0, `mode`=0, and `o_valid`=`o_toggle`=`o_busy`=0.
- Latch points: `period`←table[`i_sel`] and `mode`←`i_mode` are loaded on:
  - `i_start`=1;
  - IDLE→RUN entry;
  - every terminal count in periodic mode.
- A change to `i_sel` or `i_mode` between latch points has no effect on the current period.
- IDLE:
  - `i_start`=1 → latch, `count`←0, go to RUN (either mode).
  - `i_enable`=1 with `i_mode`=0 → latch, `count`←0, go to RUN.
  - Otherwise hold.
- RUN with `i_enable`=0: `count`, `state` and latches are held. `i_start` still restarts the count (`count`←0, latch) but no counting occurs.
- RUN with `i_enable`=1, `count`≠`period`-1: `count`←`count`+1.
- RUN with `i_enable`=1, `count`=`period`-1 (terminal count):
  - `count`←0, `o_valid`←1, `o_toggle`←~`o_toggle`.
  - Periodic: relatch and stay in RUN.
  - One-shot: go to IDLE.
- `o_valid` is 0 in every other cycle.
- Simultaneous `i_start` and terminal count: the pulse is still emitted and `o_toggle` still flips. The counter restarts from 0 with fresh latches, and the state is RUN regardless of mode (the restart wins over one-shot completion).
- `period`=1: terminal count is reached every enabled cycle, so `o_valid` stays high continuously in periodic mode.
- Counter arithmetic is unsigned, `CNT_W`-bit. `count` never exceeds `period`-1, so it never wraps.

## Timing
- Latency: if a latch/start occurs at edge t0 with `i_enable` held high, `o_valid` is 1 for exactly the cycle following edge t0+P, where P is the latched period. Subsequent pulses in periodic mode follow every P cycles.
- Each enable-low cycle extends the pulse time by exactly one cycle.
- `o_busy` rises at the edge that enters RUN. In one-shot mode it falls at the same edge that raises `o_valid`.
- Reset assertion forces outputs low immediately, with no clock required, including mid-period and mid-pulse.
- No combinational path exists from inputs to outputs.

## Test plan
All scenarios use `CNT_W`=8, `PERIOD0..3` = 4, 3, 2, 1.
- Reset, then `i_enable`=1, `i_mode`=0, `i_sel`=0 held → `o_valid` pulses on cycles 4, 8, 12 after the enabling edge; `o_toggle` reads 1, 0, 1; `o_count` cycles 0,1,2,3.
- Periodic with `i_sel` changed from 0 to 1 at `count`=1 → the current period completes at 4 cycles; subsequent pulses come every 3 cycles.
- `i_mode`=1, one `i_start` pulse with `i_sel`=2 → a single `o_valid` 2 cycles later; `o_busy` is high for 2 cycles, then IDLE with no further pulses while `i_enable` stays 1.
- Periodic P=4 with `i_enable` dropped for 3 cycles at `count`=2 → `o_count` holds 2 and the next pulse arrives 3 cycles late.
- One-shot P=4 with `i_start` asserted on the terminal cycle → pulse emitted, `o_busy` stays 1, and a second pulse arrives 4 cycles later.
- Assert `i_rst`=0 asynchronously mid-period at `count`=2 with `o_toggle`=1 → all outputs go to 0 before the next edge; after release, IDLE with `period`=4. Also run `i_sel`=3 periodic → `o_valid` held at 1 every cycle.
